// File: rtl/toy_trap_csr.sv
// toy_trap_csr: machine-mode trap CSR sequencer.
//
// Takes a trap request from the retire unit and steps through a four-state
// sequence (IDLE -> CAPTURE -> COMMIT -> ACK). On the way it latches the trap
// payload, works out the handler address and updates mepc/mcause/mtval and
// mstatus.MIE/MPIE. In IDLE it also performs the mret restore. It holds the
// software-visible copies of the M-mode trap CSRs.
//
// Optional feature: define TOY_TRAP_VECTORED_EN to make mtvec.MODE[0]
// writable. With MODE=1, interrupts then vector to base + 4*cause[30:0].
// Without it, MODE reads 0 and every trap goes to the base.
//
// Reset is synchronous and active-high.
module toy_trap_csr #(
  parameter int                   REG_WIDTH   = 32,
  parameter int                   ADDR_WIDTH  = 32,
  parameter logic [REG_WIDTH-1:0] MTVEC_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // trap port from the retire unit
  input  logic                  trap_vld,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic [31:0]           trap_cause,
  input  logic [ADDR_WIDTH-1:0] trap_extra_info,
  input  logic                  trap_indebug,
  output logic                  trap_rdy,
  input  logic                  mret_en,
  // software CSR access
  input  logic                  csr_wr_en,
  input  logic [11:0]           csr_wr_addr,
  input  logic [REG_WIDTH-1:0]  csr_wr_data,
  input  logic [11:0]           csr_rd_addr,
  output logic [REG_WIDTH-1:0]  csr_rd_data,
  // live CSR values
  output logic [REG_WIDTH-1:0]  csr_mtvec,
  output logic [REG_WIDTH-1:0]  csr_mepc,
  output logic [REG_WIDTH-1:0]  csr_mcause,
  output logic [REG_WIDTH-1:0]  csr_mtval,
  output logic                  mstatus_mie,
  output logic [ADDR_WIDTH-1:0] trap_target_pc,
  output logic                  trap_busy
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  // mtvec is WARL: MODE[1] is never writable, and MODE[0] is writable only
  // when vectored mode is built in.
  function automatic logic [REG_WIDTH-1:0] mtvec_warl(input logic [REG_WIDTH-1:0] v);
`ifdef TOY_TRAP_VECTORED_EN
    return v & ~REG_WIDTH'(2);
`else
    return v & ~REG_WIDTH'(3);
`endif
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;

  // trap payload latched on acceptance so the sequence can finish even if
  // trap_vld drops early
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_cause;
  logic [ADDR_WIDTH-1:0] r_tval;

  logic [REG_WIDTH-1:0]  r_mtvec;
  logic [REG_WIDTH-1:0]  r_mscratch;
  logic [REG_WIDTH-1:0]  r_mepc;
  logic [REG_WIDTH-1:0]  r_mcause;
  logic [REG_WIDTH-1:0]  r_mtval;
  logic                  r_mie;
  logic                  r_mpie;
  logic [ADDR_WIDTH-1:0] r_target_pc;

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_mret;
  logic                  w_wr_mstatus;
  logic                  w_wr_mtvec;
  logic                  w_wr_mscratch;
  logic                  w_wr_mepc;
  logic                  w_wr_mcause;
  logic                  w_wr_mtval;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_target;

  // State register for the trap sequencer
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: a debug-mode trap skips straight to the acknowledge
  always_comb begin
    // NOTE: default first, so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (trap_vld) w_state_nxt = trap_indebug ? ST_ACK : ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_COMMIT;
      ST_COMMIT:  w_state_nxt = ST_ACK;
      ST_ACK:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer events and software write decode
  always_comb begin
    w_accept      = (r_state == ST_IDLE) && trap_vld && !trap_indebug;
    w_commit      = (r_state == ST_COMMIT);
    // a trap in the same IDLE cycle takes priority and the mret is dropped
    w_mret        = (r_state == ST_IDLE) && mret_en && !trap_vld;
    w_wr_mstatus  = csr_wr_en && (csr_wr_addr == ADDR_MSTATUS);
    w_wr_mtvec    = csr_wr_en && (csr_wr_addr == ADDR_MTVEC);
    w_wr_mscratch = csr_wr_en && (csr_wr_addr == ADDR_MSCRATCH);
    w_wr_mepc     = csr_wr_en && (csr_wr_addr == ADDR_MEPC);
    w_wr_mcause   = csr_wr_en && (csr_wr_addr == ADDR_MCAUSE);
    w_wr_mtval    = csr_wr_en && (csr_wr_addr == ADDR_MTVAL);
  end

  // Handler address: base is mtvec with the MODE bits cleared
  always_comb begin
    w_base   = r_mtvec[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
    w_target = w_base;
`ifdef TOY_TRAP_VECTORED_EN
    // vectored interrupts only; the offset wraps modulo 2^ADDR_WIDTH
    if (r_mtvec[0] && r_cause[31])
      w_target = w_base + ADDR_WIDTH'({r_cause[30:0], 2'b00});
`endif
  end

  // Latch the trap payload on acceptance and the handler address in CAPTURE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_cause     <= '0;
      r_tval      <= '0;
      r_target_pc <= '0;
    end else begin
      if (w_accept) begin
        r_pc    <= trap_pc;
        r_cause <= trap_cause;
        r_tval  <= trap_extra_info;
      end
      if (r_state == ST_CAPTURE) r_target_pc <= w_target;
    end
  end

  // mtvec and mscratch: software writes always apply
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtvec    <= mtvec_warl(MTVEC_RESET);
      r_mscratch <= '0;
    end else begin
      if (w_wr_mtvec)    r_mtvec    <= mtvec_warl(csr_wr_data);
      if (w_wr_mscratch) r_mscratch <= csr_wr_data;
    end
  end

  // Trap-updated CSRs: the COMMIT update beats a same-cycle software write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
    end else if (w_commit) begin
      r_mepc   <= REG_WIDTH'(r_pc) & ~REG_WIDTH'(3);
      r_mcause <= REG_WIDTH'(r_cause);
      r_mtval  <= REG_WIDTH'(r_tval);
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else begin
      if (w_wr_mepc)   r_mepc   <= csr_wr_data & ~REG_WIDTH'(3);
      if (w_wr_mcause) r_mcause <= csr_wr_data;
      if (w_wr_mtval)  r_mtval  <= csr_wr_data;
      // mret is a retire-side event and takes priority over a same-cycle
      // software mstatus write
      if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
        r_mie  <= csr_wr_data[3];
        r_mpie <= csr_wr_data[7];
      end
    end
  end

  // Combinational CSR read port; unmapped addresses read zero
  always_comb begin
    csr_rd_data = '0;
    unique case (csr_rd_addr)
      ADDR_MSTATUS:  csr_rd_data = REG_WIDTH'({r_mpie, 3'b000, r_mie, 3'b000});
      ADDR_MTVEC:    csr_rd_data = r_mtvec;
      ADDR_MSCRATCH: csr_rd_data = r_mscratch;
      ADDR_MEPC:     csr_rd_data = r_mepc;
      ADDR_MCAUSE:   csr_rd_data = r_mcause;
      ADDR_MTVAL:    csr_rd_data = r_mtval;
      default:       csr_rd_data = '0;
    endcase
  end

  assign trap_rdy       = (r_state == ST_ACK);
  assign trap_busy      = (r_state != ST_IDLE);
  assign trap_target_pc = r_target_pc;
  assign csr_mtvec      = r_mtvec;
  assign csr_mepc       = r_mepc;
  assign csr_mcause     = r_mcause;
  assign csr_mtval      = r_mtval;
  assign mstatus_mie    = r_mie;

endmodule

// File: tb/tb_toy_trap_csr.sv
// Directed testbench for toy_trap_csr (default parameters).
module tb_toy_trap_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_vld;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_extra_info;
  logic        trap_indebug;
  logic        trap_rdy;
  logic        mret_en;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mcause;
  logic [31:0] csr_mtval;
  logic        mstatus_mie;
  logic [31:0] trap_target_pc;
  logic        trap_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  toy_trap_csr dut (
    .clk             (clk),
    .rst             (rst),
    .trap_vld        (trap_vld),
    .trap_pc         (trap_pc),
    .trap_cause      (trap_cause),
    .trap_extra_info (trap_extra_info),
    .trap_indebug    (trap_indebug),
    .trap_rdy        (trap_rdy),
    .mret_en         (mret_en),
    .csr_wr_en       (csr_wr_en),
    .csr_wr_addr     (csr_wr_addr),
    .csr_wr_data     (csr_wr_data),
    .csr_rd_addr     (csr_rd_addr),
    .csr_rd_data     (csr_rd_data),
    .csr_mtvec       (csr_mtvec),
    .csr_mepc        (csr_mepc),
    .csr_mcause      (csr_mcause),
    .csr_mtval       (csr_mtval),
    .mstatus_mie     (mstatus_mie),
    .trap_target_pc  (trap_target_pc),
    .trap_busy       (trap_busy)
  );

  // advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_wr_en   = 1'b1;
    csr_wr_addr = addr;
    csr_wr_data = data;
    tick();
    csr_wr_en   = 1'b0;
  endtask

  // run one trap; rdy_cycle is the first cycle with trap_rdy high, -1 if none
  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                         input logic [31:0] tval, input logic dbg,
                         output int rdy_cycle);
    rdy_cycle       = -1;
    trap_pc         = pc;
    trap_cause      = cause;
    trap_extra_info = tval;
    trap_indebug    = dbg;
    trap_vld        = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (trap_rdy === 1'b1) begin
        rdy_cycle = c;
        break;
      end
    end
    trap_vld     = 1'b0;
    trap_indebug = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    total++; if (trap_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%0b exp=0", trap_rdy); end
    total++; if (trap_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", trap_busy); end
    total++; if (trap_target_pc !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", trap_target_pc); end
    total++; if (csr_mepc !== 32'h0) begin bad++; $display("FAIL reset_mepc got=%h exp=0", csr_mepc); end
    total++; if (csr_mcause !== 32'h0) begin bad++; $display("FAIL reset_mcause got=%h exp=0", csr_mcause); end
    total++; if (csr_mtval !== 32'h0) begin bad++; $display("FAIL reset_mtval got=%h exp=0", csr_mtval); end
    total++; if (csr_mtvec !== 32'h0) begin bad++; $display("FAIL reset_mtvec got=%h exp=0", csr_mtvec); end
    csr_rd_addr = 12'h300; #1;
    total++; if (csr_rd_data !== 32'h0) begin bad++; $display("FAIL reset_mstatus got=%h exp=0", csr_rd_data); end
    csr_rd_addr = 12'h340; #1;
    total++; if (csr_rd_data !== 32'h0) begin bad++; $display("FAIL reset_mscratch got=%h exp=0", csr_rd_data); end
  endtask

  task automatic test_trap();
    csr_write(12'h300, 32'h0000_0008);
    csr_rd_addr = 12'h300; #1;
    total++; if (csr_rd_data !== 32'h0000_0008) begin bad++; $display("FAIL trap_pre_mstatus got=%h exp=00000008", csr_rd_data); end
    trap_pc = 32'h8000_0102; trap_cause = 32'd2; trap_extra_info = 32'hDEAD_BEEF;
    trap_indebug = 1'b0; trap_vld = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++; if (trap_rdy !== (c == 3)) begin bad++; $display("FAIL trap_rdy_c%0d got=%0b exp=%0b", c, trap_rdy, (c == 3)); end
      total++; if (trap_busy !== 1'b1) begin bad++; $display("FAIL trap_busy_c%0d got=%0b exp=1", c, trap_busy); end
    end
    total++; if (csr_mepc !== 32'h8000_0100) begin bad++; $display("FAIL trap_mepc got=%h exp=80000100", csr_mepc); end
    total++; if (csr_mcause !== 32'd2) begin bad++; $display("FAIL trap_mcause got=%h exp=2", csr_mcause); end
    total++; if (csr_mtval !== 32'hDEAD_BEEF) begin bad++; $display("FAIL trap_mtval got=%h exp=deadbeef", csr_mtval); end
    total++; if (mstatus_mie !== 1'b0) begin bad++; $display("FAIL trap_mie got=%0b exp=0", mstatus_mie); end
    total++; if (csr_rd_data !== 32'h0000_0080) begin bad++; $display("FAIL trap_mstatus got=%h exp=00000080", csr_rd_data); end
    total++; if (trap_target_pc !== 32'h0) begin bad++; $display("FAIL trap_target got=%h exp=0", trap_target_pc); end
    trap_vld = 1'b0;
    tick();
    total++; if (trap_rdy !== 1'b0 || trap_busy !== 1'b0) begin bad++; $display("FAIL trap_after got rdy=%0b busy=%0b exp=0/0", trap_rdy, trap_busy); end
  endtask

  task automatic test_mret();
    mret_en = 1'b1;
    total++; if (trap_busy !== 1'b0) begin bad++; $display("FAIL mret_busy_pre got=%0b exp=0", trap_busy); end
    tick();
    mret_en = 1'b0;
    csr_rd_addr = 12'h300; #1;
    total++; if (mstatus_mie !== 1'b1) begin bad++; $display("FAIL mret_mie got=%0b exp=1", mstatus_mie); end
    total++; if (csr_rd_data !== 32'h0000_0088) begin bad++; $display("FAIL mret_mstatus got=%h exp=00000088", csr_rd_data); end
    total++; if (trap_busy !== 1'b0) begin bad++; $display("FAIL mret_busy_post got=%0b exp=0", trap_busy); end
  endtask

  task automatic test_debug();
    trap_pc = 32'h0000_0500; trap_cause = 32'd3; trap_extra_info = 32'h55;
    trap_indebug = 1'b1; trap_vld = 1'b1;
    tick();
    total++; if (trap_rdy !== 1'b1) begin bad++; $display("FAIL dbg_rdy_c1 got=%0b exp=1", trap_rdy); end
    trap_vld = 1'b0; trap_indebug = 1'b0;
    tick();
    csr_rd_addr = 12'h300; #1;
    total++; if (trap_rdy !== 1'b0) begin bad++; $display("FAIL dbg_rdy_c2 got=%0b exp=0", trap_rdy); end
    total++; if (csr_mepc !== 32'h8000_0100) begin bad++; $display("FAIL dbg_mepc got=%h exp=80000100", csr_mepc); end
    total++; if (csr_mcause !== 32'd2) begin bad++; $display("FAIL dbg_mcause got=%h exp=2", csr_mcause); end
    total++; if (csr_rd_data !== 32'h0000_0088) begin bad++; $display("FAIL dbg_mstatus got=%h exp=00000088", csr_rd_data); end
  endtask

  task automatic test_sw_write();
    trap_pc = 32'h0000_0040; trap_cause = 32'd5; trap_extra_info = 32'h0;
    trap_indebug = 1'b0; trap_vld = 1'b1;
    tick();
    tick();
    // cycle 2 is COMMIT: this software write must be dropped
    csr_wr_en = 1'b1; csr_wr_addr = 12'h341; csr_wr_data = 32'h0000_1234;
    tick();
    csr_wr_en = 1'b0; trap_vld = 1'b0;
    total++; if (trap_rdy !== 1'b1) begin bad++; $display("FAIL sw_commit_rdy got=%0b exp=1", trap_rdy); end
    total++; if (csr_mepc !== 32'h0000_0040) begin bad++; $display("FAIL sw_commit_mepc got=%h exp=00000040", csr_mepc); end
    tick();
    csr_write(12'h341, 32'h0000_1237);
    csr_rd_addr = 12'h341; #1;
    total++; if (csr_mepc !== 32'h0000_1234) begin bad++; $display("FAIL sw_mepc got=%h exp=00001234", csr_mepc); end
    total++; if (csr_rd_data !== 32'h0000_1234) begin bad++; $display("FAIL sw_mepc_rd got=%h exp=00001234", csr_rd_data); end
    csr_write(12'h340, 32'hCAFE_F00D);
    csr_rd_addr = 12'h340; #1;
    total++; if (csr_rd_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL sw_mscratch got=%h exp=cafef00d", csr_rd_data); end
    csr_rd_addr = 12'h7C0; #1;
    total++; if (csr_rd_data !== 32'h0) begin bad++; $display("FAIL sw_unmapped got=%h exp=0", csr_rd_data); end
  endtask

  task automatic test_vector();
    int          rc;
    logic [31:0] exp_mtvec;
    logic [31:0] exp_tgt;
`ifdef TOY_TRAP_VECTORED_EN
    exp_mtvec = 32'h0000_1001;
    exp_tgt   = 32'h0000_101C;
`else
    exp_mtvec = 32'h0000_1000;
    exp_tgt   = 32'h0000_1000;
`endif
    csr_write(12'h305, 32'h0000_1001);
    csr_rd_addr = 12'h305; #1;
    total++; if (csr_mtvec !== exp_mtvec) begin bad++; $display("FAIL vec_mtvec got=%h exp=%h", csr_mtvec, exp_mtvec); end
    total++; if (csr_rd_data !== exp_mtvec) begin bad++; $display("FAIL vec_mtvec_rd got=%h exp=%h", csr_rd_data, exp_mtvec); end
    do_trap(32'h0000_0200, 32'h8000_0007, 32'h0, 1'b0, rc);
    total++; if (rc !== 3) begin bad++; $display("FAIL vec_irq_rdy_cycle got=%0d exp=3", rc); end
    total++; if (trap_target_pc !== exp_tgt) begin bad++; $display("FAIL vec_irq_target got=%h exp=%h", trap_target_pc, exp_tgt); end
    total++; if (csr_mcause !== 32'h8000_0007) begin bad++; $display("FAIL vec_irq_mcause got=%h exp=80000007", csr_mcause); end
    do_trap(32'h0000_0204, 32'h0000_0007, 32'h0, 1'b0, rc);
    total++; if (trap_target_pc !== 32'h0000_1000) begin bad++; $display("FAIL vec_exc_target got=%h exp=00001000", trap_target_pc); end
  endtask

  task automatic test_rst_mid();
    int rdy_seen;
    trap_pc = 32'h0000_0300; trap_cause = 32'd9; trap_extra_info = 32'h9;
    trap_indebug = 1'b0; trap_vld = 1'b1;
    tick();
    total++; if (trap_busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=1", trap_busy); end
    rst = 1'b1; trap_vld = 1'b0;
    tick();
    csr_rd_addr = 12'h300; #1;
    total++; if (trap_rdy !== 1'b0 || trap_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl got rdy=%0b busy=%0b exp=0/0", trap_rdy, trap_busy); end
    total++; if (trap_target_pc !== 32'h0) begin bad++; $display("FAIL rst_mid_target got=%h exp=0", trap_target_pc); end
    total++; if (csr_mepc !== 32'h0 || csr_mcause !== 32'h0 || csr_mtval !== 32'h0) begin bad++; $display("FAIL rst_mid_csrs got mepc=%h mcause=%h mtval=%h exp=0", csr_mepc, csr_mcause, csr_mtval); end
    total++; if (csr_mtvec !== 32'h0) begin bad++; $display("FAIL rst_mid_mtvec got=%h exp=0", csr_mtvec); end
    total++; if (csr_rd_data !== 32'h0) begin bad++; $display("FAIL rst_mid_mstatus got=%h exp=0", csr_rd_data); end
    rst = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (trap_rdy !== 1'b0) rdy_seen++;
    end
    total++; if (rdy_seen !== 0) begin bad++; $display("FAIL rst_mid_no_rdy got=%0d exp=0", rdy_seen); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] rdy_mask;
    rdy_mask = '0;
    trap_pc = 32'h0000_0080; trap_cause = 32'd1; trap_extra_info = 32'h11;
    trap_indebug = 1'b0; trap_vld = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      rdy_mask[c] = trap_rdy;
    end
    trap_vld = 1'b0;
    tick();
    total++; if (rdy_mask !== 9'b0_1000_1000) begin bad++; $display("FAIL b2b_rdy_cycles got=%b exp=010001000", rdy_mask); end
    total++; if (csr_mepc !== 32'h0000_0080) begin bad++; $display("FAIL b2b_mepc got=%h exp=00000080", csr_mepc); end
    total++; if (trap_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", trap_busy); end
  endtask

  initial begin
    rst = 1'b1;
    trap_vld = 1'b0; trap_pc = '0; trap_cause = '0; trap_extra_info = '0;
    trap_indebug = 1'b0; mret_en = 1'b0;
    csr_wr_en = 1'b0; csr_wr_addr = '0; csr_wr_data = '0; csr_rd_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_trap();
    test_mret();
    test_debug();
    test_sw_write();
    test_vector();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
